// File: rtl/load_store_unit_if.sv
// Word-wide data-memory port between the load/store unit and data memory.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // The load/store unit issues requests.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Data memory answers them.
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request/acknowledge transaction per memory op,
// byte-lane steering for stores, sign/zero extension for loads.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [5:0]        alucode,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_in,
    output logic              busy,
    load_store_unit_if.master mem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misaligned,
    output logic              bus_err
);

    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    logic        is_mem, is_load, aligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode the incoming op: memory op or not, load or store, alignment.
    always_comb begin
        is_mem  = 1'b0;
        is_load = 1'b0;
        aligned = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                aligned = 1'b1;
            end
            ALU_LH, ALU_LHU: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                aligned = ~addr[0];
            end
            ALU_LW: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                aligned = (addr[1:0] == 2'b00);
            end
            ALU_SB: begin
                is_mem  = 1'b1;
                aligned = 1'b1;
            end
            ALU_SH: begin
                is_mem  = 1'b1;
                aligned = ~addr[0];
            end
            ALU_SW: begin
                is_mem  = 1'b1;
                aligned = (addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem.mem_rdata[7:0];
            2'd1:    ld_byte = mem.mem_rdata[15:8];
            2'd2:    ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (op_q)
            ALU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            ALU_LBU: ld_data = {24'h0, ld_byte};
            ALU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            ALU_LHU: ld_data = {16'h0, ld_half};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        wbv_d    = 1'b0;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // busy_q lingers one cycle after returning to IDLE; upstream is
                // still holding then, so accepting would issue the op twice.
                if (valid_in && is_mem && !busy_q) begin
                    if (aligned) begin
                        op_d    = alucode;
                        off_d   = addr[1:0];
                        rd_d    = rd_in;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = ~is_load;
                        maddr_d = {addr[31:2], 2'b00};
                        case (alucode)
                            ALU_SB: begin
                                wdata_d = {4{store_data[7:0]}};
                                wstrb_d = 4'b0001 << addr[1:0];
                            end
                            ALU_SH: begin
                                wdata_d = {2{store_data[15:0]}};
                                wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                            end
                            ALU_SW: begin
                                wdata_d = store_data;
                                wstrb_d = 4'b1111;
                            end
                            default: begin
                                wdata_d = 32'h0;
                                wstrb_d = 4'b0000;
                            end
                        endcase
                        state_d = StWait;
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    if (!we_q) begin
                        wbv_d    = 1'b1;
                        wbrd_d   = rd_q;
                        wbdata_d = ld_data;
                    end
                    state_d = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 6'd0;
            off_q    <= 2'd0;
            rd_q     <= 5'd0;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= 32'h0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= 32'h0;
            wbv_q    <= 1'b0;
            wbrd_q   <= 5'd0;
            wbdata_q <= 32'h0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            wbv_q    <= wbv_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign busy          = busy_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;
    assign wb_valid      = wbv_q;
    assign wb_rd         = wbrd_q;
    assign wb_data       = wbdata_q;
    assign misaligned    = mis_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected events
// from a behavioural model, an independent monitor pops and compares them.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    localparam logic [5:0] LB  = 6'd9;
    localparam logic [5:0] LH  = 6'd10;
    localparam logic [5:0] LW  = 6'd11;
    localparam logic [5:0] LBU = 6'd12;
    localparam logic [5:0] LHU = 6'd13;
    localparam logic [5:0] SB  = 6'd14;
    localparam logic [5:0] SH  = 6'd15;
    localparam logic [5:0] SW  = 6'd16;

    localparam int K_REQ = 0;
    localparam int K_WB  = 1;
    localparam int K_MIS = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          len;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [5:0]  alucode = 6'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_err;

    load_store_unit_if mem_if ();

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .alucode    (alucode),
        .addr       (addr),
        .store_data (store_data),
        .rd_in      (rd_in),
        .busy       (busy),
        .mem        (mem_if.master),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic last_busy [0:63];
    int   last_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        checks++;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_order: got event %0d, expected no event", kind);
        end else if (exp_q[0].kind != kind) begin
            errors++;
            $display("FAIL event_order: got event %0d, expected event %0d", kind, exp_q[0].kind);
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Reference model: plain arithmetic on the ISA rules.
    function automatic bit m_is_mem(input logic [5:0] op);
        return op >= LB && op <= SW;
    endfunction

    function automatic bit m_is_load(input logic [5:0] op);
        return op >= LB && op <= LHU;
    endfunction

    function automatic bit m_aligned(input logic [5:0] op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return (a % 2) == 0;
        if (op == LW || op == SW) return (a % 4) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [5:0] op, input logic [31:0] a);
        if (op == SB) return 4'(1 << (a % 4));
        if (op == SH) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        if (op == SW) return 4'd15;
        return 4'd0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
        if (op == SB) return (sd & 32'hFF) * 32'h01010101;
        if (op == SH) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    // Issue one op at a negedge with busy low, acknowledge it 'delay' cycles
    // after mem_req should rise (delay >= TO means no ack in time), and run
    // until busy falls. With 'hammer', valid_in is kept high while busy.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                         input bit hammer);
        exp_t e;
        bit   done;
        valid_in   = 1'b1;
        alucode    = op;
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        if (m_is_mem(op)) begin
            if (!m_aligned(op, a)) begin
                e = '{kind: K_MIS, addr: 0, we: 0, wstrb: 0, wdata: 0, len: 0, rd: 0, data: 0};
                exp_q.push_back(e);
            end else begin
                e = '{kind: K_REQ, addr: a & 32'hFFFFFFFC, we: !m_is_load(op),
                      wstrb: m_strb(op, a), wdata: m_wdata(op, sd),
                      len: (delay < int'(TO)) ? delay + 1 : int'(TO), rd: 0, data: 0};
                exp_q.push_back(e);
                if (delay >= int'(TO)) begin
                    e = '{kind: K_ERR, addr: 0, we: 0, wstrb: 0, wdata: 0, len: 0, rd: 0, data: 0};
                    exp_q.push_back(e);
                end else if (m_is_load(op)) begin
                    e = '{kind: K_WB, addr: 0, we: 0, wstrb: 0, wdata: 0, len: 0, rd: rd,
                          data: m_load(op, a, rdata)};
                    exp_q.push_back(e);
                end
            end
        end
        done = 1'b0;
        for (int c = 1; c < 64 && !done; c++) begin
            @(negedge clk);
            last_busy[c] = busy;
            last_end     = c;
            if (c == 1 + delay) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = rdata;
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = $urandom;
            end
            if (hammer && busy) begin
                valid_in = 1'b1;
                alucode  = 6'(LB + $urandom_range(0, 7));
                addr     = $urandom;
            end else begin
                valid_in = 1'b0;
            end
            if (c >= 2 && !busy) done = 1'b1;
        end
        mem_if.mem_ack = 1'b0;
        valid_in       = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL busy_release: busy still %b after 63 cycles, expected 0", busy);
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents an event.
    initial begin
        exp_t        e, cur;
        bit          ok, in_req, stable, req_prev;
        int          len;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_strb;
        logic        s_we;
        in_req   = 1'b0;
        req_prev = 1'b0;
        stable   = 1'b1;
        len      = 0;
        cur      = '{kind: 0, addr: 0, we: 0, wstrb: 0, wdata: 0, len: -1, rd: 0, data: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                in_req   = 1'b0;
                req_prev = 1'b0;
                continue;
            end
            if (mem_if.mem_req && !in_req) begin
                in_req  = 1'b1;
                len     = 1;
                stable  = 1'b1;
                s_addr  = mem_if.mem_addr;
                s_we    = mem_if.mem_we;
                s_strb  = mem_if.mem_wstrb;
                s_wdata = mem_if.mem_wdata;
                pop_exp(K_REQ, e, ok);
                if (ok) begin
                    cur = e;
                    chk("req_addr", mem_if.mem_addr, e.addr);
                    chk("req_we", 32'(mem_if.mem_we), 32'(e.we));
                    chk("req_wstrb", 32'(mem_if.mem_wstrb), 32'(e.wstrb));
                    if (e.we) chk("req_wdata", mem_if.mem_wdata, e.wdata);
                end else begin
                    cur.len = -1;
                end
            end else if (mem_if.mem_req && in_req) begin
                len++;
                if (mem_if.mem_addr !== s_addr || mem_if.mem_we !== s_we ||
                    mem_if.mem_wstrb !== s_strb || mem_if.mem_wdata !== s_wdata)
                    stable = 1'b0;
            end else if (!mem_if.mem_req && in_req) begin
                in_req = 1'b0;
                chk("req_stable", 32'(stable), 32'd1);
                if (cur.len >= 0) chk("req_length", 32'(len), 32'(cur.len));
            end
            if (wb_valid) begin
                pop_exp(K_WB, e, ok);
                chk("wb_timing", {30'h0, req_prev, mem_if.mem_req}, 32'd2);
                if (ok) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (bus_err) begin
                pop_exp(K_ERR, e, ok);
                chk("err_timing", {30'h0, req_prev, mem_if.mem_req}, 32'd2);
            end
            if (misaligned) begin
                pop_exp(K_MIS, e, ok);
                chk("mis_quiet", {30'h0, busy, mem_if.mem_req}, 32'd0);
            end
            req_prev = mem_if.mem_req;
        end
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          dly;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {24'h0, busy, mem_if.mem_req, mem_if.mem_we, wb_valid,
                           misaligned, bus_err, 2'b00}, 32'h0);
        chk("reset_addr", mem_if.mem_addr, 32'h0);
        chk("reset_wdata", mem_if.mem_wdata, 32'h0);
        chk("reset_wstrb_rd", {23'h0, mem_if.mem_wstrb, wb_rd}, 32'h0);
        chk("reset_wb_data", wb_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(LW, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_busy_window", {28'h0, last_busy[1], last_busy[2], last_busy[3], last_busy[4]},
            32'hE);
        do_op(LB, 32'h103, 32'h0, 5'd6, 1, 32'h80123456, 1'b0);
        do_op(LBU, 32'h103, 32'h0, 5'd7, 2, 32'h80123456, 1'b0);
        do_op(LHU, 32'h102, 32'h0, 5'd8, 0, 32'h80123456, 1'b0);
        do_op(SH, 32'h206, 32'h0000ABCD, 5'd9, 1, 32'h0, 1'b0);
        do_op(LW, 32'h101, 32'h0, 5'd1, 0, 32'h0, 1'b0);
        chk("mis_lw_busy", {30'h0, last_busy[1], last_busy[2]}, 32'h0);
        do_op(LH, 32'h103, 32'h0, 5'd2, 0, 32'h0, 1'b0);
        chk("mis_lh_busy", {30'h0, last_busy[1], last_busy[2]}, 32'h0);
        do_op(SW, 32'h300, 32'h12345678, 5'd3, int'(TO), 32'h0, 1'b0);
        chk("timeout_idle_cycle", 32'(last_end), 32'd7);
        do_op(LW, 32'h400, 32'h0, 5'd10, 2, 32'hCAFEF00D, 1'b1);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) op = 6'(17 + $urandom_range(0, 20));
            else op = 6'(LB + $urandom_range(0, 7));
            a   = $urandom;
            dly = $urandom_range(0, 5) == 0 ? int'(TO) : int'($urandom_range(0, TO - 1));
            do_op(op, a, $urandom, 5'($urandom), dly, $urandom, 1'($urandom));
        end

        // Reset in the middle of WAIT: request drops at once, nothing follows.
        valid_in = 1'b1;
        alucode  = LW;
        addr     = 32'h500;
        rd_in    = 5'd11;
        exp_q.push_back('{kind: K_REQ, addr: 32'h500, we: 0, wstrb: 0, wdata: 0, len: -1,
                          rd: 0, data: 0});
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_req_drop", {30'h0, mem_if.mem_req, busy}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_quiet", {29'h0, mem_if.mem_req, wb_valid, busy}, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I core.
- Takes the effective address the ALU produces for `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW`, plus the store operand.
- Runs one request/acknowledge transaction on a word-wide data-memory port.
- Returns sign- or zero-extended load data to writeback, and stalls the pipeline while a transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 16: maximum number of cycles spent in WAIT before the access is abandoned with bus_err. Legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  ALU-stage result valid this cycle
- alucode  in  6  operation code, shared define.vh encoding
- addr  in  32  effective address (ALU alu_result)
- store_data  in  32  rs2 value for stores
- rd_in  in  5  destination register for loads
- busy  out  1  high while state is not IDLE; upstream holds and stalls
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  32  store data replicated into lanes
- mem_ack  in  1  memory accepted/completed request
- mem_rdata  in  32  read data, valid with mem_ack
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- misaligned  out  1  one-cycle pulse: misaligned access rejected
- bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; timeout counter 0; captured op/addr/data/rd cleared. Any in-flight transaction is dropped; no wb_valid follows.
- All outputs are registered.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Memory alucode with valid_in=1 and aligned address → capture op, addr[1:0], store_data, rd_in; next cycle mem_req=1 and state=WAIT.
  - Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=0; B is always aligned.
  - Misaligned memory op → no mem_req; misaligned=1 for one cycle; state stays IDLE.
  - Non-memory alucode, or valid_in=0 → no effect.
- WAIT:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until the mem_ack cycle.
  - Counter increments each cycle without ack.
  - mem_ack=1 → mem_req drops next cycle. Load: wb_data and wb_rd registered, wb_valid=1 for one cycle. Store: no wb_valid. Next state DONE.
  - Counter reaches ACK_TIMEOUT without ack → mem_req drops, bus_err=1 for one cycle, state DONE, no writeback.
- DONE: one cycle, busy=1; then IDLE. This guarantees at least one idle cycle between requests.
- busy = (state != IDLE), registered. valid_in while busy is ignored; upstream must not advance.
- Store lanes:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = sd, wstrb = 4'b1111.
  - Loads: wstrb = 0, we = 0.
- Load extract: byte lane = rdata >> (8*addr[1:0]); half lane = rdata >> (16*addr[1]).
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend.
  - LW passes rdata unchanged.
- Latency: valid_in at cycle 0 → mem_req high at cycle 1. Ack at cycle k → wb_valid at cycle k+1. Minimum 3 cycles from issue back to IDLE.
- mem_ack while not in WAIT is ignored.

Test Plan:
- LW addr=0x100, mem acks on cycle 1 with rdata=0xDEADBEEF → mem_addr=0x100, wb_valid at cycle 2, wb_data=0xDEADBEEF, wb_rd=rd_in, busy for cycles 1-3.
- LB addr=0x103 with rdata=0x80123456 → wb_data=0xFFFFFF80. Same with LBU → 0x00000080. LHU addr=0x102 → 0x00008012.
- SH addr=0x206, store_data=0x0000ABCD → mem_we=1, mem_addr=0x204, wstrb=4'b1100, wdata=0xABCDABCD, no wb_valid.
- LW addr=0x101 and LH addr=0x103 → misaligned pulses one cycle each, mem_req never asserted, busy stays 0.
- ACK_TIMEOUT=4, SW with mem_ack held 0 → mem_req held 4 cycles with stable signals, then bus_err pulse, IDLE two cycles later. Then assert rst mid-WAIT on a second access → mem_req=0 immediately and no wb_valid afterwards.
- Second LW with valid_in asserted while busy → ignored; it is accepted only after busy falls, with exactly one mem_req per accepted op.
